div_ctrl: RTL and testbench

Iterative 32-bit divider sequencer for the EX stage. It accepts a divide request from the EX control logic and runs a restoring shift-subtract loop, one quotient bit per cycle. It applies sign correction for signed division and returns quotient and remainder with a one-cycle `done` pulse. While a division is in progress it raises `busy` so the pipeline controller stalls IF/ID/EX; the combinational logic/shift unit is unaffected.

---
 rtl/div_ctrl.sv | 114 +++++++++++
 tb/tb_div_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// Iterative restoring divider sequencer for the EX stage: one quotient bit per
// cycle, sign correction for DIV, results held until the next completed op.
module div_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            signed_div,
    input  logic            flush,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            div_by_zero
);

    typedef enum logic [1:0] {IDLE, DIV, SIGN, DONE} state_t;

    state_t          state;
    state_t          state_next;
    logic [4:0]      count;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] shreg;
    logic [XLEN-1:0] dvs;
    logic            q_neg;
    logic            r_neg;
    logic            accept;
    logic            zero_div;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   trial;

    function automatic logic [XLEN-1:0] neg_if(input logic neg, input logic [XLEN-1:0] v);
        return neg ? ({XLEN{1'b0}} - v) : v;
    endfunction

    assign accept   = ((state == IDLE) || (state == DONE)) && start && !flush;
    assign zero_div = (divisor == '0);

    // A successful trial is never negative, so its top bit is always clear and
    // the partial remainder only needs XLEN bits of storage between iterations.
    assign shifted = {rem, shreg[XLEN-1]};
    assign trial   = shifted - {1'b0, dvs};

    assign busy = (state == DIV) || (state == SIGN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: state_next = accept ? (zero_div ? DONE : DIV) : IDLE;
            DIV:        if (count == 5'd31) state_next = SIGN;
            SIGN:       state_next = DONE;
            default:    state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            count <= '0;
            if (zero_div) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end else begin
                q_neg <= signed_div & (dividend[XLEN-1] ^ divisor[XLEN-1]);
                r_neg <= signed_div & dividend[XLEN-1];
            end
        end else if (!flush) begin
            if (state == DIV) count <= count + 5'd1;
            // A flush landing on the SIGN edge leaves the previous results intact.
            if (state == SIGN) begin
                quotient    <= neg_if(q_neg, shreg);
                remainder   <= neg_if(r_neg, rem);
                div_by_zero <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !zero_div) begin
            rem   <= '0;
            shreg <= neg_if(signed_div & dividend[XLEN-1], dividend);
            dvs   <= neg_if(signed_div & divisor[XLEN-1], divisor);
        end else if ((state == DIV) && !flush) begin
            if (!trial[XLEN]) begin
                rem   <= trial[XLEN-1:0];
                shreg <= {shreg[XLEN-2:0], 1'b1};
            end else begin
                rem   <= shifted[XLEN-1:0];
                shreg <= {shreg[XLEN-2:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: arithmetic reference model checked every cycle, plus
// directed operations with hand-computed results and latencies.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start = 1'b0;
    logic        signed_div = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    div_ctrl #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_div(signed_div),
        .flush(flush), .dividend(dividend), .divisor(divisor), .busy(busy),
        .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference results straight from arithmetic on magnitudes.
    function automatic void calc(input logic [31:0] a, input logic [31:0] b, input logic s,
                                 output logic [31:0] q, output logic [31:0] r);
        logic [31:0] ua, ub, uq, ur;
        if (b == 0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else begin
            ua = (s && a[31]) ? -a : a;
            ub = (s && b[31]) ? -b : b;
            uq = ua / ub;
            ur = ua % ub;
            q = (s && (a[31] ^ b[31])) ? -uq : uq;
            r = (s && a[31]) ? -ur : ur;
        end
    endfunction

    // Model: an op with nonzero divisor is busy for 33 cycles, then done.
    int          m_cnt;
    logic        m_done, m_z;
    logic [31:0] m_q, m_r, p_q, p_r, t_q, t_r;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0; m_done <= 0; m_q <= 0; m_r <= 0; m_z <= 0;
        end else if (flush) begin
            m_cnt <= 0; m_done <= 0;
        end else if (m_cnt == 0) begin
            m_done <= 0;
            if (start) begin
                calc(dividend, divisor, signed_div, t_q, t_r);
                if (divisor == 0) begin
                    m_q <= t_q; m_r <= t_r; m_z <= 1; m_done <= 1;
                end else begin
                    m_cnt <= 33; p_q <= t_q; p_r <= t_r;
                end
            end
        end else begin
            m_done <= 0;
            if (m_cnt == 1) begin
                m_q <= p_q; m_r <= p_r; m_z <= 0; m_done <= 1;
            end
            m_cnt <= m_cnt - 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_busy", 32'(busy), 32'(m_cnt > 0));
            chk("m_done", 32'(done), 32'(m_done));
            chk("m_quot", quotient, m_q);
            chk("m_rem", remainder, m_r);
            chk("m_dbz", 32'(div_by_zero), 32'(m_z));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int cyc, output int nbusy);
        cyc = 1;
        nbusy = 0;
        while (!done && cyc < 100) begin
            if (busy) nbusy++;
            tick();
            cyc++;
        end
    endtask

    task automatic op(input string name, input logic [31:0] a, input logic [31:0] b,
                      input logic s, input logic [31:0] eq, input logic [31:0] er,
                      input logic ez);
        int cyc, nb;
        start = 1; signed_div = s; dividend = a; divisor = b;
        tick();
        start = 0;
        wait_done(cyc, nb);
        chk({name, "_lat"}, 32'(cyc), (b == 0) ? 32'd1 : 32'd34);
        chk({name, "_busy"}, 32'(nb), (b == 0) ? 32'd0 : 32'd33);
        chk({name, "_q"}, quotient, eq);
        chk({name, "_r"}, remainder, er);
        chk({name, "_dbz"}, 32'(div_by_zero), 32'(ez));
        tick();
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'(($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 20));
            3: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int cyc, nb, seen;
        rst_n = 1;
        #1 rst_n = 0;
        #2;
        chk("rst_q", quotient, 32'd0);
        chk("rst_r", remainder, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        chk_en = 1;
        tick();

        op("u100_7", 32'd100, 32'd7, 0, 32'd14, 32'd2, 0);
        op("sm7_2", 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
        op("s7_m2", 32'd7, 32'hFFFF_FFFE, 1, 32'hFFFF_FFFD, 32'd1, 0);
        op("dz", 32'h1234_5678, 32'd0, 0, 32'hFFFF_FFFF, 32'h1234_5678, 1);
        op("sovf", 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 32'd0, 0);
        op("umax", 32'hFFFF_FFFF, 32'd1, 0, 32'hFFFF_FFFF, 32'd0, 0);

        // Flush part-way through a division keeps the earlier 9/4 result.
        op("u9_4", 32'd9, 32'd4, 0, 32'd2, 32'd1, 0);
        start = 1; signed_div = 0; dividend = 100; divisor = 7;
        tick();
        start = 0;
        repeat (10) tick();
        flush = 1;
        tick();
        flush = 0;
        chk("fl_busy", 32'(busy), 32'd0);
        seen = 0;
        repeat (40) begin
            if (done || busy) seen++;
            tick();
        end
        chk("fl_nodone", 32'(seen), 32'd0);
        chk("fl_q", quotient, 32'd2);
        chk("fl_r", remainder, 32'd1);

        // start and flush together: nothing starts.
        start = 1; flush = 1; dividend = 50; divisor = 5;
        tick();
        start = 0; flush = 0;
        seen = 0;
        repeat (40) begin
            if (done || busy) seen++;
            tick();
        end
        chk("sf_idle", 32'(seen), 32'd0);

        // start held through DONE: next op begins with no idle gap.
        start = 1; signed_div = 0; dividend = 1000; divisor = 10;
        tick();
        signed_div = 1; dividend = -32'd100; divisor = 7;
        wait_done(cyc, nb);
        chk("b2b1_lat", 32'(cyc), 32'd34);
        chk("b2b1_q", quotient, 32'd100);
        chk("b2b1_r", remainder, 32'd0);
        tick();
        start = 0;
        chk("b2b2_busy", 32'(busy), 32'd1);
        wait_done(cyc, nb);
        chk("b2b2_lat", 32'(cyc), 32'd34);
        chk("b2b2_q", quotient, 32'hFFFF_FFF2);
        chk("b2b2_r", remainder, 32'hFFFF_FFFE);
        tick();

        // Reset mid-division clears outputs without waiting for a clock.
        start = 1; signed_div = 0; dividend = 32'hFFFF; divisor = 3;
        tick();
        start = 0;
        repeat (5) tick();
        #2 rst_n = 0;
        #1;
        chk("mr_q", quotient, 32'd0);
        chk("mr_r", remainder, 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1;
        tick();
        chk("mr_idle", 32'(busy), 32'd0);

        // Random cycle-level stimulus against the model.
        for (int i = 0; i < 4000; i++) begin
            start      = ($urandom_range(0, 2) == 0);
            flush      = ($urandom_range(0, 59) == 0);
            signed_div = $urandom_range(0, 1);
            dividend   = rnd32();
            divisor    = rnd32();
            tick();
        end
        start = 0; flush = 0;
        repeat (40) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
